// File: rtl/onehot_decode_pipe.sv
// Three-stage select decoder: input reg, hi/lo predecode reg, one-hot output reg.
// Each stage loads on its own, so bubbles collapse under backpressure.
module onehot_decode_pipe #(
   parameter int SEL_W = 3,
   parameter int LO_W  = SEL_W / 2
) (
   input  logic                  clock0,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic                  in_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2**SEL_W-1:0]   out_onehot,
   output logic                  busy
);

   localparam int OUT_W = 2 ** SEL_W;
   localparam int HI_W  = SEL_W - LO_W;
   localparam int HN    = 2 ** HI_W;
   localparam int LN    = 2 ** LO_W;

   logic             v1_q, v1_d;
   logic             en1_q, en1_d;
   logic [SEL_W-1:0] sel1_q, sel1_d;
   logic             v2_q, v2_d;
   logic             en2_q, en2_d;
   logic [HN-1:0]    hi2_q, hi2_d;
   logic [LN-1:0]    lo2_q, lo2_d;
   logic             v3_q, v3_d;
   logic [OUT_W-1:0] out_q, out_d;

   logic             ld1, ld2, ld3;
   logic [HN-1:0]    hi_dec;
   logic [LN-1:0]    lo_dec;
   logic [OUT_W-1:0] and_dec;

   always_comb begin
      ld3 = ~v3_q | out_ready;
      ld2 = ~v2_q | ld3;
      ld1 = ~v1_q | ld2;
   end

   assign in_ready   = ld1 & ~reset;
   assign out_valid  = v3_q;
   assign out_onehot = out_q;
   assign busy       = v1_q | v2_q | v3_q;

   always_comb begin
      hi_dec = '0;
      lo_dec = '0;
      hi_dec[sel1_q[SEL_W-1:LO_W]] = 1'b1;
      lo_dec[sel1_q[LO_W-1:0]]     = 1'b1;
   end

   // Output bit i = its hi group AND its lo group
   for (genvar i = 0; i < OUT_W; i++) begin : g_and
      assign and_dec[i] = hi2_q[i / LN] & lo2_q[i % LN] & en2_q;
   end

   always_comb begin
      v1_d   = v1_q;
      sel1_d = sel1_q;
      en1_d  = en1_q;
      v2_d   = v2_q;
      hi2_d  = hi2_q;
      lo2_d  = lo2_q;
      en2_d  = en2_q;
      v3_d   = v3_q;
      out_d  = out_q;
      if (ld1) begin
         v1_d = in_valid;
         if (in_valid) begin
            sel1_d = in_sel;
            en1_d  = in_en;
         end
      end
      if (ld2) begin
         v2_d = v1_q;
         if (v1_q) begin
            hi2_d = hi_dec;
            lo2_d = lo_dec;
            en2_d = en1_q;
         end
      end
      if (ld3) begin
         v3_d = v2_q;
         if (v2_q) begin
            out_d = and_dec;
         end
      end
   end

   always_ff @(posedge clock0) begin
      if (reset) begin
         v1_q   <= 1'b0;
         sel1_q <= '0;
         en1_q  <= 1'b0;
         v2_q   <= 1'b0;
         hi2_q  <= '0;
         lo2_q  <= '0;
         en2_q  <= 1'b0;
         v3_q   <= 1'b0;
         out_q  <= '0;
      end else begin
         v1_q   <= v1_d;
         sel1_q <= sel1_d;
         en1_q  <= en1_d;
         v2_q   <= v2_d;
         hi2_q  <= hi2_d;
         lo2_q  <= lo2_d;
         en2_q  <= en2_d;
         v3_q   <= v3_d;
         out_q  <= out_d;
      end
   end

endmodule

// File: tb/tb_onehot_decode_pipe.sv
// Directed bench for onehot_decode_pipe with a negedge scoreboard
// that tracks every handshake in both directions.
module tb_onehot_decode_pipe;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_sel;
   logic       in_en;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_onehot;
   logic       busy;

   int n_chk  = 0;
   int n_pass = 0;
   int n_acc  = 0;
   logic [7:0] sbq[$];

   always #5 clk = ~clk;

   onehot_decode_pipe #(.SEL_W(3)) dut (
      .clock0    (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_en     (in_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_onehot(out_onehot),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   function automatic logic [7:0] model(input logic [2:0] s, input logic e);
      logic [7:0] w;
      w = 8'h00;
      if (e) w[s] = 1'b1;
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Inputs change 1 after posedge, so negedge sees what the next edge sees
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         sbq.delete();
      end else begin
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbq.size() == 0) chk("sb_spurious", {24'h0, out_onehot}, 32'hdead);
            else chk("sb_word", {24'h0, out_onehot}, {24'h0, sbq.pop_front()});
         end
         if (in_valid === 1'b1 && in_ready === 1'b1) begin
            sbq.push_back(model(in_sel, in_en));
            n_acc++;
         end
      end
   end

   initial begin
      int start;
      int cyc;
      reset     = 1'b1;
      in_valid  = 1'b1;
      in_sel    = 3'd6;
      in_en     = 1'b1;
      out_ready = 1'b1;

      // Reset held 2 cycles with in_valid high
      step();
      chk("rst_in_ready", in_ready, 0);
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_onehot", out_onehot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready2", in_ready, 0);
      reset    = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) step();
      chk("rst_quiet", out_valid, 0);
      chk("rst_quiet_busy", busy, 0);

      // Back-to-back sweep with latency check
      in_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_sel   = 3'(i);
         chk("sweep_ready", in_ready, 1);
         step();
         if (i < 2) chk("sweep_lat", out_valid, 0);
         else chk("sweep_word", out_onehot, 32'(8'h01 << (i - 2)));
      end
      in_valid = 1'b0;
      step();
      chk("sweep_w6", out_onehot, 32'h40);
      step();
      chk("sweep_w7", out_onehot, 32'h80);
      chk("sweep_v7", out_valid, 1);
      step();
      chk("sweep_drain", out_valid, 0);
      chk("sweep_hold", out_onehot, 32'h80);

      // Enable low still produces a valid zero word
      in_valid = 1'b1;
      in_sel   = 3'd5;
      in_en    = 1'b0;
      step();
      in_en = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("en0_valid", out_valid, 1);
      chk("en0_word", out_onehot, 32'h00);
      step();
      chk("en1_word", out_onehot, 32'h20);
      step();
      chk("en_drain", out_valid, 0);

      // Backpressure: three stages fill, fourth waits
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_sel = 3'(i);
         chk("bp_ready", in_ready, 1);
         step();
      end
      in_sel = 3'd4;
      chk("bp_full", in_ready, 0);
      chk("bp_v", out_valid, 1);
      chk("bp_w", out_onehot, 32'h02);
      step();
      step();
      chk("bp_stall_w", out_onehot, 32'h02);
      chk("bp_stall_v", out_valid, 1);
      chk("bp_stall_rdy", in_ready, 0);
      out_ready = 1'b1;
      #1;
      chk("bp_comb_rdy", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("bp_w2", out_onehot, 32'h04);
      step();
      chk("bp_w3", out_onehot, 32'h08);
      step();
      chk("bp_w4", out_onehot, 32'h10);
      step();
      chk("bp_drain", out_valid, 0);

      // Sparse traffic with random backpressure against the scoreboard
      start = n_acc;
      cyc   = 0;
      while ((n_acc - start < 40 || sbq.size() != 0) && cyc < 2000) begin
         in_valid  = (n_acc - start < 40) && ($urandom_range(0, 2) != 0);
         in_sel    = 3'($urandom_range(0, 7));
         in_en     = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 1) != 0);
         step();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("rand_done", 32'(cyc < 2000), 1);
      chk("rand_empty", sbq.size(), 0);
      step();
      chk("rand_idle", busy, 0);

      // Mid-flight reset drops two transactions
      in_en    = 1'b1;
      in_valid = 1'b1;
      in_sel   = 3'd3;
      step();
      in_sel = 3'd6;
      step();
      in_valid = 1'b0;
      reset    = 1'b1;
      step();
      chk("mid_busy", busy, 0);
      chk("mid_v", out_valid, 0);
      chk("mid_rdy", in_ready, 0);
      chk("mid_word", out_onehot, 0);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("mid_quiet", out_valid, 0);
      end
      in_valid = 1'b1;
      in_sel   = 3'd7;
      step();
      in_valid = 1'b0;
      step();
      chk("mid_lat", out_valid, 0);
      step();
      chk("mid_v7", out_valid, 1);
      chk("mid_w7", out_onehot, 32'h80);
      step();
      chk("mid_drain", out_valid, 0);
      chk("mid_sb", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
